// File: rtl/mem_pkg.sv
// Shared types and helpers for the store merge path: FSM state encoding,
// byte-lane masks and the store alignment check.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam logic [31:0] MASK_B0 = 32'h0000_00FF;
    localparam logic [31:0] MASK_B1 = 32'h0000_FF00;
    localparam logic [31:0] MASK_B2 = 32'h00FF_0000;
    localparam logic [31:0] MASK_B3 = 32'hFF00_0000;
    localparam logic [31:0] MASK_H0 = 32'h0000_FFFF;
    localparam logic [31:0] MASK_H1 = 32'hFFFF_0000;
    localparam logic [31:0] MASK_W  = 32'hFFFF_FFFF;

    // Byte stores are always aligned and take priority over Half.
    function automatic logic is_misaligned(input logic       byte_i,
                                           input logic       half_i,
                                           input logic [1:0] lo_i);
        logic mis;
        if (byte_i) begin
            mis = 1'b0;
        end else if (half_i) begin
            mis = lo_i[0];
        end else begin
            mis = (lo_i != 2'b00);
        end
        return mis;
    endfunction

    // Little-endian lane mask of the bits a store replaces.
    function automatic logic [31:0] lane_mask(input logic       byte_i,
                                              input logic       half_i,
                                              input logic [1:0] lo_i);
        logic [31:0] m;
        if (byte_i) begin
            case (lo_i)
                2'd0:    m = MASK_B0;
                2'd1:    m = MASK_B1;
                2'd2:    m = MASK_B2;
                default: m = MASK_B3;
            endcase
        end else if (half_i) begin
            m = lo_i[1] ? MASK_H1 : MASK_H0;
        end else begin
            m = MASK_W;
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational merge of sub-word store data into an existing RAM word.
// The new data is replicated across all lanes and the lane mask picks
// which bits of the old word get replaced.
module byte_lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic        byte_i,
    input  logic        half_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] merged_o
);

    logic [31:0] repl;
    logic [31:0] mask;

    // Replicate the store data so every candidate lane carries it, then mask.
    always_comb begin
        if (byte_i) begin
            repl = {4{new_i[7:0]}};
        end else if (half_i) begin
            repl = {2{new_i[15:0]}};
        end else begin
            repl = new_i;
        end
        mask     = lane_mask(byte_i, half_i, lane_i);
        merged_o = (old_i & ~mask) | (repl & mask);
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store path between the core and the word-wide data RAM. Word stores are
// written one cycle after acceptance; byte/halfword stores run a
// read-modify-write sequence that stalls the core for three cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no store pending; accepts an aligned request
// READ  | RAM read strobe out for the captured word address
// WAIT  | read data valid; merge captured lane(s) into the old word
// WRITE | RAM write strobe out, done pulse, stall released
module store_merge_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              Byte,
    input  logic              Half,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata
);

    state_e              state_q, state_d;

    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_rd_en_q;
    logic                mem_wr_en_q;
    logic [31:0]         mem_wdata_q;

    logic [31:0]         wdata_q;
    logic                byte_q;
    logic                half_q;
    logic [1:0]          lane_q;

    logic                misalign;
    logic                sub_word;
    logic                accept;
    logic [31:0]         merged;

    // Upper address bits lie outside the RAM and are deliberately dropped.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    assign misalign = is_misaligned(Byte, Half, addr[1:0]);
    assign sub_word = Byte | Half;
    assign accept   = (state_q == IDLE) && req && !misalign;

    byte_lane_merge u_merge (
        .old_i    (mem_rdata),
        .new_i    (wdata_q),
        .byte_i   (byte_q),
        .half_i   (half_q),
        .lane_i   (lane_q),
        .merged_o (merged)
    );

    // State register; reset abandons any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; req is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = sub_word ? READ : WRITE;
                end
            end
            READ:    state_d = WAIT;
            WAIT:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Combinational core-facing outputs; forced low while reset is held.
    always_comb begin
        stall = 1'b0;
        err   = 1'b0;
        done  = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    stall = req && !misalign;
                    err   = req && misalign;
                end
                READ:    stall = 1'b1;
                WAIT:    stall = 1'b1;
                WRITE:   done  = 1'b1;
                default: ;
            endcase
        end
    end

    // Capture the accepted store; Byte wins over Half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q <= '0;
            wdata_q    <= '0;
            byte_q     <= 1'b0;
            half_q     <= 1'b0;
            lane_q     <= 2'd0;
        end else if (accept) begin
            mem_addr_q <= addr[ADDR_W+1:2];
            wdata_q    <= wdata;
            byte_q     <= Byte;
            half_q     <= Half & ~Byte;
            lane_q     <= addr[1:0];
        end
    end

    // RAM strobes are registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
        end else begin
            mem_rd_en_q <= (state_d == READ);
            mem_wr_en_q <= (state_d == WRITE);
        end
    end

    // Write data: the full word on a word store, the merged word after WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wdata_q <= '0;
        end else if (accept && !sub_word) begin
            mem_wdata_q <= wdata;
        end else if (state_q == WAIT) begin
            mem_wdata_q <= merged;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: a small RAM model answers reads one cycle
// after the strobe, expected writes go into a scoreboard queue when a store
// is issued and are popped whenever the DUT raises mem_wr_en.
module tb_store_merge_unit;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              req;
    logic              Byte;
    logic              Half;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              stall;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;

    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [31:0]       pre_data;

    logic [63:0]       sb_q[$];
    int                n_checks;
    int                n_pass;

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .Byte      (Byte),
        .Half      (Half),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with one-cycle read latency and a bench preload port.
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        mem_rdata <= mem_rd_en ? ram[mem_addr] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Scoreboard: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(mem_addr), e[63:32]);
                check("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    // Independent per-byte reference of a store landing on an old word.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic b, input logic h, input logic [1:0] lo);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (b) begin
                if (k == int'(lo)) r[8*k +: 8] = d[7:0];
            end else if (h) begin
                if ((k / 2) == int'(lo[1])) r[8*k +: 8] = d[8*(k%2) +: 8];
            end else begin
                r[8*k +: 8] = d[8*k +: 8];
            end
        end
        return r;
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Issue one aligned store and check stall/strobe timing cycle by cycle.
    task automatic run_store(input logic b, input logic h, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp, input bit hold_req);
        int n_cyc;
        n_cyc = (b || h) ? 3 : 1;
        @(posedge clk); #1;
        req = 1'b1; Byte = b; Half = h; addr = a; wdata = d;
        sb_q.push_back({32'(a[ADDR_W+1:2]), exp});
        @(negedge clk);
        check("stall_accept", 32'(stall), 32'd1);
        check("err_accept", 32'(err), 32'd0);
        for (int c = 1; c <= n_cyc; c++) begin
            @(posedge clk); #1;
            if (!hold_req) req = 1'b0;
            @(negedge clk);
            if (c < n_cyc) begin
                check("stall_rmw", 32'(stall), 32'd1);
                check("rd_en_rmw", 32'(mem_rd_en), (c == 1) ? 32'd1 : 32'd0);
                if (c == 1) check("rd_addr", 32'(mem_addr), 32'(a[ADDR_W+1:2]));
                check("done_rmw", 32'(done), 32'd0);
            end else begin
                check("stall_write", 32'(stall), 32'd0);
                check("done_write", 32'(done), 32'd1);
                check("wr_en_write", 32'(mem_wr_en), 32'd1);
            end
        end
        @(posedge clk); #1;
        req = 1'b0; Byte = 1'b0; Half = 1'b0;
        @(negedge clk);
        check("idle_after_wr", 32'(mem_wr_en), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    // Misaligned request: flagged, no stall, and no RAM strobe follows.
    task automatic run_misaligned(input logic h, input logic [31:0] a);
        @(posedge clk); #1;
        req = 1'b1; Byte = 1'b0; Half = h; addr = a; wdata = 32'h5555_AAAA;
        @(negedge clk);
        check("mis_err", 32'(err), 32'd1);
        check("mis_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        req = 1'b0; Half = 1'b0;
        @(negedge clk);
        check("mis_rd_en", 32'(mem_rd_en), 32'd0);
        check("mis_wr_en", 32'(mem_wr_en), 32'd0);
        check("mis_err_clr", 32'(err), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_word;
        logic [31:0] nxt;
        logic [31:0] d;
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; req = 1'b0; Byte = 1'b0; Half = 1'b0;
        addr = '0; wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Word store
        run_store(1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        check("ram4_word", ram[4], 32'hDEAD_BEEF);

        // Byte and halfword stores over a known word
        preload(10'd4, 32'h1122_3344);
        run_store(1'b1, 1'b0, 32'h12, 32'h0000_00AB, 32'h11AB_3344, 1'b0);
        preload(10'd4, 32'h1122_3344);
        run_store(1'b0, 1'b1, 32'h12, 32'h0000_CAFE, 32'hCAFE_3344, 1'b0);
        preload(10'd4, 32'h1122_3344);
        run_store(1'b0, 1'b1, 32'h10, 32'h0000_CAFE, 32'h1122_CAFE, 1'b0);

        // Misaligned halfword then misaligned word
        run_misaligned(1'b1, 32'h13);
        run_misaligned(1'b0, 32'h11);
        check("ram4_untouched_mis", ram[4], 32'h1122_CAFE);

        // Reset during WAIT of a byte store
        preload(10'd4, 32'h1122_3344);
        @(posedge clk); #1;
        req = 1'b1; Byte = 1'b1; Half = 1'b0; addr = 32'h12; wdata = 32'hAB;
        @(posedge clk); #1;
        req = 1'b0; Byte = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_in_wait", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_rd", 32'(mem_rd_en), 32'd0);
        check("mid_rst_wr", 32'(mem_wr_en), 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        check("ram4_after_rst", ram[4], 32'h1122_3344);
        run_store(1'b0, 1'b0, 32'h14, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        check("ram5_after_rst", ram[5], 32'h0BAD_F00D);

        // req held through WRITE; Byte+Half treated as byte
        preload(10'd4, 32'h1122_3344);
        run_store(1'b1, 1'b1, 32'h13, 32'h0000_0077, 32'h7722_3344, 1'b1);
        run_store(1'b0, 1'b0, 32'h18, 32'h1234_5678, 32'h1234_5678, 1'b1);
        check("ram4_bh", ram[4], 32'h7722_3344);

        // Walk every byte lane, then both halves, on one word
        preload(10'd8, 32'h0);
        exp_word = 32'h0;
        for (int k = 0; k < 4; k++) begin
            d   = 32'($urandom_range(255, 0)) | 32'hFF00_0000;
            nxt = ref_merge(exp_word, d, 1'b1, 1'b0, 2'(k));
            run_store(1'b1, 1'b0, 32'h20 + 32'(k), d, nxt, 1'b0);
            exp_word = nxt;
        end
        for (int k = 0; k < 2; k++) begin
            d   = $urandom;
            nxt = ref_merge(exp_word, d, 1'b0, 1'b1, 2'(2*k));
            run_store(1'b0, 1'b1, 32'h20 + 32'(2*k), d, nxt, 1'b0);
            exp_word = nxt;
        end
        check("ram8_final", ram[8], exp_word);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side companion to the load-extension path: takes byte, halfword and word store requests from the single-cycle core and writes them into the word-wide data RAM. Word stores are written directly. Byte and halfword stores use a read-modify-write sequence that stalls the core. The block sits between the core's store control/ALU result and the data RAM port, in parallel with the load data path.

## Interface

Parameters:
- ADDR_W, default 10: word-address width of the data RAM.

Ports:
- clk  in  1: clock. One clock domain.
- rst_n  in  1: reset, asynchronous, active-low.
- req  in  1: store instruction present this cycle.
- Byte  in  1: byte store (sb). Takes priority over Half.
- Half  in  1: halfword store (sh).
- addr  in  32: byte address, the ALU result.
- wdata  in  32: rt value. Low byte or low halfword is used for sub-word stores.
- stall  out  1: combinational; holds the PC and instruction while high.
- done  out  1: one-cycle pulse in the cycle the RAM write occurs.
- err  out  1: combinational misalignment flag; no write is performed.
- mem_addr  out  ADDR_W: word address, equal to addr[ADDR_W+1:2], registered.
- mem_rd_en  out  1: RAM read strobe, registered.
- mem_rdata  in  32: RAM read data, valid the cycle after mem_rd_en.
- mem_wr_en  out  1: RAM write strobe, registered.
- mem_wdata  out  32: RAM write data, registered.

## Operation

- Byte lanes are little-endian:
  - Byte: addr[1:0]=0..3 selects bits [7:0], [15:8], [23:16], [31:24].
  - Half: addr[1]=0 selects bits [15:0]; addr[1]=1 selects bits [31:16].
- Alignment:
  - Misaligned means a Half store with addr[0]=1, or a word store with addr[1:0]≠0.
  - Byte stores are never misaligned.
  - Misaligned request in IDLE: err=1 that cycle, stall=0, no state change, no RAM access.
- FSM states: IDLE, READ, WAIT, WRITE.
  - IDLE, aligned word store (req, Byte=0, Half=0): capture addr and wdata, then go to WRITE.
  - IDLE, aligned sub-word store: capture addr, wdata, Byte, Half and the lane index, then go to READ.
  - READ: mem_rd_en=1 with the mem_addr of the captured store. Go to WAIT.
  - WAIT: latch mem_rdata into the merge register, replacing only the selected lane(s) with the captured data. Go to WRITE.
  - WRITE: mem_wr_en=1, done=1, mem_wdata = merged word (or the captured word for word stores). Go to IDLE.
- stall = (IDLE & req & aligned) | READ | WAIT.
  - stall is low in WRITE, so the core advances at the end of that cycle.
- req is ignored in READ, WAIT and WRITE. The held instruction is not re-accepted.
- Byte=1 with Half=1 is treated as a byte store.
- No store is pending while req=0 in IDLE; all strobes stay low.

## Timing

- Reset value of every output is 0: stall, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata. State resets to IDLE.
- Word store: accepted at T, written at T+1. Stall is high for 1 cycle.
- Sub-word store: accepted at T, read at T+1, merge at T+2, written at T+3. Stall is high for 3 cycles.
- RAM read latency is fixed at 1 cycle. mem_rdata is sampled only in WAIT.
- Reset asserted mid-sequence: return to IDLE immediately, drop all strobes, discard the pending write. Memory is untouched unless WRITE had already completed.
- A new request may be accepted in the cycle after WRITE. There is no back-to-back overlap.

## Structure

- Shared package `mem_pkg`:
  - state enum: IDLE=2'd0, READ=2'd1, WAIT=2'd2, WRITE=2'd3;
  - lane-mask constants;
  - misalignment check function.
- Sub-module `byte_lane_merge` (combinational):
  - inputs: old word, new data, Byte, Half, addr[1:0];
  - output: merged word.
  - It can be verified standalone.
- Top level holds the FSM, the capture registers and the output registers.

## Test plan

- Word store: addr=0x10, wdata=0xDEADBEEF → mem_wr_en with mem_addr=4 and mem_wdata=0xDEADBEEF at T+1; stall high only at T.
- Byte store: RAM[4]=0x11223344, addr=0x12, wdata=0xAB → read at T+1, mem_wdata=0x11AB3344 at T+3; stall high at T..T+2; done at T+3.
- Half store: RAM[4]=0x11223344, addr=0x12, wdata=0xCAFE → mem_wdata=0xCAFE3344. With addr=0x10 instead → mem_wdata=0x1122CAFE.
- Misalignment: Half store at addr=0x13, then word store at addr=0x11 → err=1, stall=0, no mem_rd_en or mem_wr_en in either case.
- Reset mid-operation: assert rst_n=0 during WAIT of a byte store → all outputs 0 immediately, no write. The next store after reset completes normally.
- req held high through WRITE → exactly one write. Byte=Half=1 at addr=0x13, wdata=0x77 → byte lane 3 written.
